// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready
// requesters, granting bounded bursts and never writing into a full FIFO.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t          state_r, state_s;
  logic [ID_W-1:0] gnt_r, gnt_s;
  logic [ID_W-1:0] last_r, last_s;
  logic [3:0]      beats_r, beats_s;
  logic [ID_W-1:0] idx_s, sel_s;
  logic            any_s;
  logic            xfer_s;

  // Rotating-priority search: scan from last+N down to last+1 so the nearest valid index wins.
  always_comb begin
    idx_s = '0;
    sel_s = last_r;
    any_s = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = ID_W'((int'(last_r) + k) % N_REQ);
      if (req_valid[idx_s]) begin
        sel_s = idx_s;
        any_s = 1'b1;
      end else begin
        any_s = any_s;
      end
    end
  end

  assign xfer_s = (state_r == GRANT) && req_valid[gnt_r] && !fifo_full;

  // Output decode; reset forces everything to the idle values so a beat in the reset cycle is dropped.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    if ((state_r == GRANT) && !rst) begin
      req_ready[gnt_r] = !fifo_full;
      fifo_wr_en       = xfer_s;
      fifo_wr_data     = req_data[gnt_r*DATA_W +: DATA_W];
      grant_valid      = 1'b1;
      grant_id         = gnt_r;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Next-state logic; a stall (valid while full) holds the grant without counting a beat.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    last_s  = last_r;
    beats_s = beats_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s = GRANT;
          gnt_s   = sel_s;
          last_s  = sel_s;
          beats_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req_valid[gnt_r]) begin
          state_s = IDLE;
        end else if (!fifo_full) begin
          beats_s = beats_r + 4'd1;
          if ((beats_r + 4'd1) == MAX_BURST_C) begin
            state_s = IDLE;
          end else begin
            state_s = GRANT;
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers; last starts at N_REQ-1 so requester 0 has first priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      last_r  <= ID_W'(N_REQ - 1);
      beats_r <= 4'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      beats_r <= beats_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester queues drive the DUT,
// a scoreboard of {grant_id, data} checks every FIFO write in order.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_wr_data;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  int tests = 0;
  int fails = 0;

  logic [N-1:0]    en = '0;
  logic [N-1:0]    hs_r = '0;
  bit              noise = 1'b0;
  logic [W-1:0]    src_q [N][$];
  logic [IW+W-1:0] exp_q [$];

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle: retire accepted words, then present each requester's head word.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_r[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      if (src_q[i].size() > 0) req_data[i*W +: W] = src_q[i][0];
      else if (noise) req_data[i*W +: W] = 8'($urandom);
      else req_data[i*W +: W] = 8'h00;
    end
  endtask

  // Scoreboard monitor at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [N-1:0]    allowed;
        logic [IW+W-1:0] got;
        logic [IW+W-1:0] want;
        hs_r = req_valid & req_ready;
        allowed = grant_valid ? (4'b0001 << grant_id) : 4'b0000;
        tests++;
        if ((req_ready & ~allowed) !== 4'b0000) begin
          fails++;
          $display("FAIL ready_mask: req_ready=%b grant_valid=%b grant_id=%0d", req_ready, grant_valid, grant_id);
        end
        if (fifo_wr_en === 1'b1) begin
          got = {grant_id, fifo_wr_data};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got id=%0d data=%h, expected no write", grant_id, fifo_wr_data);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              fails++;
              $display("FAIL write_data: got id=%0d data=%h, expected id=%0d data=%h",
                       got[IW+W-1:W], got[W-1:0], want[IW+W-1:W], want[W-1:0]);
            end
          end
          tests++;
          if (fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL write_while_full: fifo_wr_en=1 with fifo_full=%b, expected 0", fifo_full);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    tests++;
    if ({grant_valid, grant_id, fifo_wr_en, req_ready} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: gv=%b id=%0d wr=%b ready=%b, expected all 0",
               grant_valid, grant_id, fifo_wr_en, req_ready);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({grant_valid, grant_id, fifo_wr_en, req_ready} !== 8'h00) begin
      fails++;
      $display("FAIL reset_release: gv=%b id=%0d wr=%b ready=%b, expected all 0",
               grant_valid, grant_id, fifo_wr_en, req_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] tbl [6];
    tbl = '{4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b0000};
    src_q[0].push_back(8'h11); src_q[0].push_back(8'h22); src_q[0].push_back(8'h33);
    exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd0, 8'h22}); exp_q.push_back({2'd0, 8'h33});
    en = 4'b0001;
    for (int t = 0; t < 6; t++) begin
      step();
      @(negedge clk);
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en} !== tbl[t]) begin
        fails++;
        $display("FAIL single cycle %0d: {gv,id,wr}=%b, expected %b", t, {grant_valid, grant_id, fifo_wr_en}, tbl[t]);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_drain: %0d writes missing, expected 0", exp_q.size());
    end
    en = 4'b0000;
  endtask

  task automatic test_contested();
    logic [3:0] want;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(k));
    for (int i = 1; i < N; i++)
      for (int k = 0; k < 4; k++) src_q[i].push_back(8'(i*16 + k));
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd0, 8'(k)});
    for (int i = 1; i < N; i++)
      for (int k = 0; k < 4; k++) exp_q.push_back({IW'(i), 8'(i*16 + k)});
    for (int k = 4; k < 8; k++) exp_q.push_back({2'd0, 8'(k)});
    en = 4'b1111;
    for (int t = 0; t < 25; t++) begin
      step();
      @(negedge clk);
      want = (t % 5 == 0) ? 4'b0000 : {1'b1, IW'((t / 5) % 4), 1'b1};
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en} !== want) begin
        fails++;
        $display("FAIL contested cycle %0d: {gv,id,wr}=%b, expected %b", t, {grant_valid, grant_id, fifo_wr_en}, want);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL contested_drain: %0d writes missing, expected 0", exp_q.size());
    end
    en = 4'b0000;
  endtask

  task automatic test_stall();
    logic [4:0] tbl [12];
    tbl = '{5'b00000, 5'b11011, 5'b11011, 5'b11000, 5'b11000, 5'b11000,
            5'b11011, 5'b11011, 5'b00000, 5'b11011, 5'b11001, 5'b00000};
    for (int k = 0; k < 5; k++) begin
      src_q[2].push_back(8'hA0 + 8'(k));
      exp_q.push_back({2'd2, 8'hA0 + 8'(k)});
    end
    en = 4'b0100;
    for (int t = 0; t < 12; t++) begin
      step();
      fifo_full = (t >= 3 && t <= 5);
      @(negedge clk);
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en, req_ready[2]} !== tbl[t]) begin
        fails++;
        $display("FAIL stall cycle %0d: {gv,id,wr,rdy2}=%b, expected %b", t,
                 {grant_valid, grant_id, fifo_wr_en, req_ready[2]}, tbl[t]);
      end
    end
    fifo_full = 1'b0;
    en = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] tbl [14];
    tbl = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001,
            4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(8'hC0 + 8'(k));
      exp_q.push_back({2'd0, 8'hC0 + 8'(k)});
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd3, 8'hD0 + 8'(k)});
    en = 4'b1001;
    for (int t = 0; t < 14; t++) begin
      step();
      if (t == 2) begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) src_q[3].push_back(8'hD0 + 8'(k));
      end
      if (t == 3) rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en} !== tbl[t]) begin
        fails++;
        $display("FAIL reset_mid cycle %0d: {gv,id,wr}=%b, expected %b", t, {grant_valid, grant_id, fifo_wr_en}, tbl[t]);
      end
      if (t == 2) begin
        tests++;
        if (req_ready !== 4'b0000) begin
          fails++;
          $display("FAIL reset_mid_ready: req_ready=%b during reset, expected 0000", req_ready);
        end
      end
    end
    en = 4'b0000;
  endtask

  task automatic test_drop();
    logic [3:0] tbl [17];
    tbl = '{4'b0000, 4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
            4'b0000, 4'b0000, 4'b1011, 4'b1010, 4'b0000, 4'b1111, 4'b1110, 4'b0000};
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_q[1].push_back(8'h51); src_q[1].push_back(8'h52);
    for (int k = 0; k < 4; k++) src_q[3].push_back(8'h71 + 8'(k));
    exp_q.push_back({2'd1, 8'h51}); exp_q.push_back({2'd1, 8'h52});
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd3, 8'h71 + 8'(k)});
    exp_q.push_back({2'd1, 8'h55}); exp_q.push_back({2'd3, 8'h77});
    en = 4'b1010;
    for (int t = 0; t < 17; t++) begin
      step();
      if (t == 9) begin
        src_q[1].push_back(8'h55);
        src_q[3].push_back(8'h77);
      end
      @(negedge clk);
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en} !== tbl[t]) begin
        fails++;
        $display("FAIL drop cycle %0d: {gv,id,wr}=%b, expected %b", t, {grant_valid, grant_id, fifo_wr_en}, tbl[t]);
      end
    end
    en = 4'b0000;
  endtask

  task automatic test_isolation();
    logic [3:0] tbl [6];
    tbl = '{4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(8'h81 + 8'(k));
      exp_q.push_back({2'd0, 8'h81 + 8'(k)});
    end
    en = 4'b0001;
    noise = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      @(negedge clk);
      tests++;
      if ({grant_valid, grant_id, fifo_wr_en} !== tbl[t]) begin
        fails++;
        $display("FAIL isolation cycle %0d: {gv,id,wr}=%b, expected %b", t, {grant_valid, grant_id, fifo_wr_en}, tbl[t]);
      end
      tests++;
      if (req_ready[3:1] !== 3'b000) begin
        fails++;
        $display("FAIL isolation_ready cycle %0d: req_ready[3:1]=%b, expected 000", t, req_ready[3:1]);
      end
    end
    noise = 1'b0;
    en = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contested();
    test_stall();
    test_reset_mid();
    test_drop();
    test_isolation();
    step();
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_drain: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single 8-bit write port of the `fifo` block between `N_REQ` requesters. Each requester uses a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives `wr_en`/`wr_data` of the FIFO directly. It honours `fifo_full` so no write is ever issued to a full FIFO. It sits between the producer blocks and the FIFO instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: data width; must match the FIFO data width.
- `MAX_BURST`, 4: maximum accepted beats per grant (1..15).
- `ID_W`, $clog2(N_REQ): width of the grant index.

- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: bit i high means requester i presents a word.
- `req_data` input N_REQ*DATA_W: requester i data in bits [i*DATA_W +: DATA_W].
- `req_ready` output N_REQ: bit i high means requester i's word is accepted this cycle if valid.
- `fifo_full` input 1: FIFO full flag.
- `fifo_wr_en` output 1: FIFO write enable.
- `fifo_wr_data` output DATA_W: FIFO write data.
- `grant_valid` output 1: a requester currently holds the grant.
- `grant_id` output ID_W: index of the granted requester; 0 when `grant_valid`=0.

## Operation
- FSM has two states, IDLE and GRANT.
- Registers:
  - `state`
  - `gnt` (ID_W)
  - `last` (ID_W): last granted index
  - `beats` (4 bits)
- IDLE:
  - If any `req_valid` bit is high, select the first set bit searching `last+1`, `last+2`, … modulo N_REQ.
  - Next state is GRANT, with `gnt`=selected, `last`=selected, `beats`=0.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ready[gnt]` = !`fifo_full`. All other `req_ready` bits = 0.
  - A transfer occurs when `req_valid[gnt]` && !`fifo_full`. On a transfer:
    - `fifo_wr_en`=1 and `fifo_wr_data`=`req_data[gnt]`, both combinational.
    - `beats` increments.
  - Go to IDLE when a transfer brings `beats` to MAX_BURST.
  - Go to IDLE when `req_valid[gnt]`=0 in a GRANT cycle, regardless of `fifo_full`.
  - A cycle with `req_valid[gnt]`=1 and `fifo_full`=1 is a stall. It holds the grant and does not count as a beat. There is no stall timeout.
- Outputs in IDLE: `fifo_wr_en`=0, `req_ready`=0, `grant_valid`=0, `grant_id`=0.
- In GRANT: `grant_valid`=1 and `grant_id`=`gnt`.
- Requester rules:
  - Once `req_valid` is asserted, the requester holds it and keeps `req_data` stable until `req_ready` is seen.
  - Deasserting `req_valid` while granted forfeits the grant.
- Non-granted requesters are ignored and never accepted. Their data is never written.
- Reset:
  - `state`=IDLE, `gnt`=0, `last`=N_REQ-1 (so requester 0 has first priority), `beats`=0.
  - All outputs as in IDLE.
  - Reset asserted mid-burst aborts the burst. The beat in the reset cycle is not written, because `fifo_wr_en` is forced to 0 while `rst`=1.

## Timing
- Arbitration latency is 1 cycle: `req_valid` seen at edge k gives `grant_valid`=1 during cycle k+1. The first transfer can occur in cycle k+1.
- Data path is combinational from `req_data`/`req_valid`/`fifo_full` to the FIFO write port. There is no extra pipeline latency. The word is captured by the FIFO on the same posedge as the handshake.
- Each grant release costs one IDLE bubble cycle.
- Contested throughput is MAX_BURST words per MAX_BURST+1 cycles.
- `fifo_full` rising in the middle of a burst blocks the write in that same cycle. There is no overflow, and no write ever occurs with `fifo_full`=1.
- `fifo_full` falling resumes transfers in the same cycle.
- `last` updates only on the IDLE→GRANT transition, so it skips requesters that are not valid.

## Test plan
- Single requester 0 sends 3 words (0x11, 0x22, 0x33) with the FIFO empty:
  - `grant_valid` rises one cycle after `req_valid`.
  - 3 consecutive `fifo_wr_en` pulses carry 0x11, 0x22, 0x33.
  - Release occurs when valid drops; the FIFO then reads back 0x11, 0x22, 0x33.
- All 4 requesters continuously valid with MAX_BURST=4:
  - Grant order is 0,1,2,3,0.
  - Exactly 4 writes per grant, with 1 idle cycle between grants.
- `fifo_full` forced high for 3 cycles mid-burst by requester 2:
  - `req_ready`=0 and `fifo_wr_en`=0 for those 3 cycles, and the grant stays on 2.
  - The burst completes its remaining beats afterwards.
  - The beat count excludes stall cycles.
- Requester 1 drops `req_valid` after 2 beats while requester 3 is waiting:
  - Grant releases after 2 beats.
  - Next grant goes to 3, and `last`=3.
- `rst` asserted in the 2nd beat of a burst:
  - No write occurs in the reset cycle.
  - Outputs are 0 in the following cycle.
  - Requester 0 is granted first after reset even if requester 3 is also valid.
- Non-granted requester data changes while requester 0 is granted:
  - `fifo_wr_data` only ever carries requester 0 data.
  - `req_ready[1..3]` stays 0 throughout.
